// File: rtl/apb_mem_responder.sv
// -----------------------------------------------------------------------------
// apb_mem_responder
//   Byte-wide wait-state memory that sits behind an APB slave. It captures one
//   read or write request, waits a programmable number of cycles, and then
//   pulses ready for exactly one cycle. On a read, rdata carries the word.
//
// Handshake: a request is valid in IDLE when ce=1 and exactly one of wren or
//   rden is high. The request is captured on that edge (E0). The master must
//   keep ce high until it sees ready. Dropping ce in WAIT aborts the request:
//   there is no write and no ready. ready is a registered one-cycle pulse in
//   the DONE state. The master drops ce by the edge that ends DONE. If ce is
//   still high in the following IDLE cycle, a new transaction starts.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   reset        in   asynchronous, active-low reset
//   ce           in   chip enable (request valid while high)
//   wren, rden   in   write / read request
//   addr         in   word address (8 bits)
//   wdata        in   write data
//   rdata        out  read data, valid with ready after a read, then held
//   ready        out  one-cycle completion pulse
//   o_dbg_state  out  FSM state (0=IDLE, 1=WAIT, 2=DONE)
// -----------------------------------------------------------------------------
module apb_mem_responder #(
  parameter int          DEPTH     = 256,
  parameter int          READ_LAT  = 2,
  parameter int          WRITE_LAT = 1,
  parameter logic [7:0]  INIT_VAL  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       wren,
  input  logic       rden,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ready,
  output logic [1:0] o_dbg_state
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAXLAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CW     = $clog2(MAXLAT) + 1;

  localparam logic [CW-1:0] RD_CNT = CW'(READ_LAT - 1);
  localparam logic [CW-1:0] WR_CNT = CW'(WRITE_LAT - 1);
  localparam logic [8:0]    DEPTH9 = 9'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_op_wr;
  logic [7:0]    r_addr;
  logic [7:0]    r_wdata;
  logic [7:0]    r_rdata;
  logic          r_ready;
  logic [7:0]    r_mem [DEPTH];

  logic          w_req;
  logic          w_in_range;
  logic [AW-1:0] w_idx;

  // Both enables high at once is an illegal request and is ignored.
  assign w_req      = ce & (wren ^ rden);
  // Only the captured address is used once the request is in flight.
  assign w_in_range = ({1'b0, r_addr} < DEPTH9);
  assign w_idx      = r_addr[AW-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op_wr <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
      r_ready <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= INIT_VAL;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          if (w_req) begin
            r_op_wr <= wren;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= wren ? WR_CNT : RD_CNT;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (!ce) begin
            // Abort: the request is dropped without a side effect.
            r_state <= IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= DONE;
            r_ready <= 1'b1;
            if (r_op_wr) begin
              // An out-of-range write completes normally but changes nothing.
              if (w_in_range) begin
                r_mem[w_idx] <= r_wdata;
              end
            end else begin
              r_rdata <= w_in_range ? r_mem[w_idx] : 8'hFF;
            end
          end
        end
        DONE: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rdata       = r_rdata;
  assign ready       = r_ready;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_apb_mem_responder
//   Instance 0: DEPTH=256, READ_LAT=2, WRITE_LAT=1, INIT_VAL=00
//   Instance 1: DEPTH=128, READ_LAT=3, WRITE_LAT=4, INIT_VAL=3E
//   The driver pushes the expected rdata for every transaction that should
//   complete. The monitor pops one entry for each ready pulse and compares it.
// -----------------------------------------------------------------------------
module tb_apb_mem_responder;

  localparam logic [1:0] S_IDLE = 2'd0;

  logic       clk;
  logic       rst_n [2];
  logic       ce    [2];
  logic       wren  [2];
  logic       rden  [2];
  logic [7:0] addr  [2];
  logic [7:0] wdata [2];
  logic [7:0] rdata [2];
  logic       ready [2];
  logic [1:0] st    [2];

  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  logic [7:0] held   [2];
  logic       prev_rdy [2];

  int n_cmp = 0;
  int n_bad = 0;

  apb_mem_responder #(.DEPTH(256), .READ_LAT(2), .WRITE_LAT(1), .INIT_VAL(8'h00)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .ce(ce[0]), .wren(wren[0]), .rden(rden[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]),
    .o_dbg_state(st[0])
  );

  apb_mem_responder #(.DEPTH(128), .READ_LAT(3), .WRITE_LAT(4), .INIT_VAL(8'h3E)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .ce(ce[1]), .wren(wren[1]), .rden(rden[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]),
    .o_dbg_state(st[1])
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (actual running, required done)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs(input int d);
    ce[d]    = 1'b0;
    wren[d]  = 1'b0;
    rden[d]  = 1'b0;
    addr[d]  = 8'h00;
    wdata[d] = 8'h00;
  endtask

  // Full transaction: push the expected rdata and drive the request. Then
  // scramble addr/wdata while waiting, and check the ready latency.
  task automatic txn(input int d, input bit wr, input logic [7:0] a,
                     input logic [7:0] wd, input logic [7:0] exp_rd, input int lat);
    int k;
    if (!wr) held[d] = exp_rd;
    if (d == 0) exp_q0.push_back(held[d]);
    else        exp_q1.push_back(held[d]);
    @(negedge clk);
    ce[d] = 1'b1; wren[d] = wr; rden[d] = !wr; addr[d] = a; wdata[d] = wd;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      addr[d]  = ~a;
      wdata[d] = ~wd;
      if (ready[d]) break;
    end
    chk($sformatf("latency_d%0d_%s_%h", d, wr ? "wr" : "rd", a), 8'(k), 8'(lat + 1));
    idle_inputs(d);
  endtask

  // Monitor: one expected entry per ready pulse. Each pulse must be a single cycle.
  initial begin
    logic [7:0] e;
    prev_rdy[0] = 1'b0;
    prev_rdy[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (ready[d]) begin
          chk($sformatf("ready_one_cycle_d%0d", d), {7'd0, prev_rdy[d]}, 8'h00);
          if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ready_d%0d: actual ready=1 required ready=0 at %0t", d, $time);
          end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("rdata_d%0d", d), rdata[d], e);
          end
        end
        prev_rdy[d] = ready[d];
      end
    end
  end

  initial begin
    int cnt;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      idle_inputs(d);
      held[d] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ready_d%0d", d), {7'd0, ready[d]}, 8'h00);
      chk($sformatf("reset_rdata_d%0d", d), rdata[d], 8'h00);
      chk($sformatf("reset_state_d%0d", d), {6'd0, st[d]}, {6'd0, S_IDLE});
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // 1: read the initial contents
    txn(0, 1'b0, 8'h10, 8'h00, 8'h00, 2);
    // 2: write then read back; the write leaves rdata alone
    txn(0, 1'b1, 8'h3C, 8'hA5, 8'h00, 1);
    txn(0, 1'b0, 8'h3C, 8'h00, 8'hA5, 2);
    txn(0, 1'b1, 8'hFF, 8'h69, 8'h00, 1);
    txn(0, 1'b1, 8'h00, 8'h96, 8'h00, 1);
    txn(0, 1'b0, 8'hFF, 8'h00, 8'h69, 2);
    txn(0, 1'b0, 8'h00, 8'h00, 8'h96, 2);

    // 3: abort a read by dropping ce one cycle after capture
    @(negedge clk);
    ce[0] = 1'b1; rden[0] = 1'b1; addr[0] = 8'h20;
    @(negedge clk);
    idle_inputs(0);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready[0]) cnt++;
    end
    chk("abort_no_ready", 8'(cnt), 8'h00);
    chk("abort_state_idle", {6'd0, st[0]}, {6'd0, S_IDLE});
    txn(0, 1'b1, 8'h20, 8'h5A, 8'h00, 1);
    txn(0, 1'b0, 8'h20, 8'h00, 8'h5A, 2);

    // 4: an illegal request with both enables high is ignored
    @(negedge clk);
    ce[0] = 1'b1; wren[0] = 1'b1; rden[0] = 1'b1; addr[0] = 8'h00; wdata[0] = 8'hEE;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready[0]) cnt++;
    end
    chk("illegal_no_ready", 8'(cnt), 8'h00);
    chk("illegal_state_idle", {6'd0, st[0]}, {6'd0, S_IDLE});
    idle_inputs(0);
    txn(0, 1'b0, 8'h00, 8'h00, 8'h96, 2);

    // 5: reset during WAIT discards the write and restores the initial contents
    txn(1, 1'b1, 8'h44, 8'h77, 8'h00, 4);
    txn(1, 1'b0, 8'h44, 8'h00, 8'h77, 3);
    @(negedge clk);
    ce[1] = 1'b1; wren[1] = 1'b1; addr[1] = 8'h44; wdata[1] = 8'hC3;
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    chk("rst_wait_ready", {7'd0, ready[1]}, 8'h00);
    chk("rst_wait_state", {6'd0, st[1]}, {6'd0, S_IDLE});
    chk("rst_wait_rdata", rdata[1], 8'h00);
    idle_inputs(1);
    held[1] = 8'h00;
    @(negedge clk);
    rst_n[1] = 1'b1;
    txn(1, 1'b0, 8'h44, 8'h00, 8'h3E, 3);

    // 6: out-of-range accesses with DEPTH=128
    txn(1, 1'b1, 8'h80, 8'h11, 8'h00, 4);
    txn(1, 1'b0, 8'h80, 8'h00, 8'hFF, 3);
    txn(1, 1'b1, 8'h7F, 8'h11, 8'h00, 4);
    txn(1, 1'b0, 8'h7F, 8'h00, 8'h11, 3);
    txn(1, 1'b0, 8'h00, 8'h00, 8'h3E, 3);

    repeat (4) @(negedge clk);
    chk("queue0_drained", 8'(exp_q0.size()), 8'h00);
    chk("queue1_drained", 8'(exp_q1.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
